// File: rtl/repeated_adder_unit.sv
// ---------------------------------------------------------------------------
// repeated_adder_unit
//
// Sequential signed x unsigned multiplier built from repeated addition. The
// signed multiplicand a is added into a 16-bit accumulator b times, one
// addition per enabled clock. It forms the integral-term contribution
// (error x integral constant) in the PID controller datapath.
//
// Operation: LOAD (latch operands, clear accumulator) -> b x ADD -> DONE
// (publish the clipped product) -> LOAD again on the current inputs. One
// operation therefore takes b+2 enabled cycles. Inputs are only sampled in
// LOAD.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous reset, ACTIVE-HIGH despite the name (1 = reset);
//                has priority over ena and aborts any operation in flight
//   ena          clock enable; 0 freezes all state and outputs
//   a            signed multiplicand (IN_W bits)
//   b            unsigned repeat count (IN_W bits)
//   a_times_b    signed product reduced to OUT_W bits, registered; changes
//                only in DONE
//   temp_result  signed running accumulator (ACC_W bits), registered
//   flag         additions completed in the current operation, registered
//
// Build option:
//   REPEATED_ADDER_SAT_EN  defined   : DONE saturates the product to the
//                                      OUT_W signed range
//                          undefined : DONE takes the low OUT_W bits of the
//                                      accumulator (two's-complement wrap)
// ---------------------------------------------------------------------------
module repeated_adder_unit #(
    parameter int IN_W  = 6,
    parameter int ACC_W = 16,
    parameter int OUT_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic signed [IN_W-1:0]  a,
    input  logic        [IN_W-1:0]  b,
    output logic signed [OUT_W-1:0] a_times_b,
    output logic signed [ACC_W-1:0] temp_result,
    output logic        [IN_W-1:0]  flag
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Saturation bounds of an OUT_W-bit signed value, held at accumulator
    // width so the comparisons below are signed and width-matched.
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    state_t                    state_q;
    logic signed [IN_W-1:0]    a_l_q;
    logic        [IN_W-1:0]    b_l_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic        [IN_W-1:0]    flag_q;
    logic signed [OUT_W-1:0]   prod_q;

    logic signed [ACC_W-1:0]   acc_d;
    logic        [IN_W-1:0]    flag_d;
    logic signed [OUT_W-1:0]   clip_d;

    // Next accumulator / counter values used by ADD, and the product that
    // DONE will publish from the finished accumulator.
    always_comb begin
        acc_d  = acc_q + {{(ACC_W - IN_W){a_l_q[IN_W-1]}}, a_l_q};
        flag_d = flag_q + 1'b1;
`ifdef REPEATED_ADDER_SAT_EN
        if (acc_q > SAT_MAX) begin
            clip_d = SAT_MAX[OUT_W-1:0];
        end else if (acc_q < SAT_MIN) begin
            clip_d = SAT_MIN[OUT_W-1:0];
        end else begin
            clip_d = acc_q[OUT_W-1:0];
        end
`else
        clip_d = acc_q[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_LOAD;
            a_l_q   <= '0;
            b_l_q   <= '0;
            acc_q   <= '0;
            flag_q  <= '0;
            prod_q  <= '0;
        end else if (ena) begin
            case (state_q)
                ST_LOAD: begin
                    a_l_q  <= a;
                    b_l_q  <= b;
                    acc_q  <= '0;
                    flag_q <= '0;
                    state_q <= (b != '0) ? ST_ADD : ST_DONE;
                end
                ST_ADD: begin
                    acc_q  <= acc_d;
                    flag_q <= flag_d;
                    // Compare against the incremented count so the last
                    // addition and the exit decision happen in one cycle.
                    if (flag_d == b_l_q) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    prod_q  <= clip_d;
                    state_q <= ST_LOAD;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign a_times_b   = prod_q;
    assign temp_result = acc_q;
    assign flag        = flag_q;

    // Full magnitude is |a|*b <= 32*63, so acc_q never overflows and its
    // sign bit is the product sign.

endmodule

// File: tb/tb_repeated_adder_unit.sv
// ---------------------------------------------------------------------------
// tb_repeated_adder_unit
//
// Drives operations into repeated_adder_unit and compares every enabled (and
// stalled) cycle against a reference built from plain arithmetic: after the
// i-th addition the accumulator must equal a*i, the counter i, and the
// published product changes only at the (b+2)-th enabled cycle, to the
// reduced value of a*b.
// ---------------------------------------------------------------------------
module tb_repeated_adder_unit;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic signed [5:0] a;
    logic        [5:0] b;
    logic signed [5:0] a_times_b;
    logic signed [15:0] temp_result;
    logic        [5:0] flag;

    int n_vec;
    int n_err;
    int prev_prod;

    repeated_adder_unit #(
        .IN_W (6),
        .ACC_W(16),
        .OUT_W(6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .a          (a),
        .b          (b),
        .a_times_b  (a_times_b),
        .temp_result(temp_result),
        .flag       (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Product reduction the published output must follow.
    function automatic int reduce(input int v);
        logic [5:0] low;
`ifdef REPEATED_ADDER_SAT_EN
        if (v > 31) return 31;
        if (v < -32) return -32;
`endif
        low = v[5:0];
        return int'($signed(low));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int acc, input int cnt, input int prod);
        check_val({tag, ".acc"},  int'(temp_result), acc);
        check_val({tag, ".flag"}, int'(flag), cnt);
        check_val({tag, ".prod"}, int'(a_times_b), prod);
    endtask

    // One complete operation starting at a LOAD edge. mid_change scrambles the
    // inputs right after LOAD; stall_at>0 drops ena for 3 cycles after that
    // many additions.
    task automatic run_op(input int av, input int bv, input bit mid_change, input int stall_at);
        int exp_prod;
        a = 6'(av);
        b = 6'(bv);
        tick();                                   // LOAD
        check_state("load", 0, 0, prev_prod);
        if (mid_change) begin
            a = 6'($urandom_range(0, 63));
            b = 6'($urandom_range(0, 63));
        end
        for (int i = 1; i <= bv; i++) begin
            tick();                               // ADD #i
            check_state("add", av * i, i, prev_prod);
            if (i == stall_at) begin
                ena = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check_state("stall", av * i, i, prev_prod);
                end
                ena = 1'b1;
            end
        end
        tick();                                   // DONE
        exp_prod = reduce(av * bv);
        check_state("done", av * bv, bv, exp_prod);
        check_val("sign", int'(temp_result[15]), (av * bv < 0) ? 1 : 0);
        $display("op a=%0d b=%0d -> a_times_b=%0d (expect %0d) acc=%0d",
                 av, bv, a_times_b, exp_prod, temp_result);
        prev_prod = exp_prod;
    endtask

    int dir_a [] = '{3, 1, 2, 4, -1, -2, -3, -4, 2, 2, -2, -2, 0, 5, -32, 31};
    int dir_b [] = '{10, 30, 15, 5, 30, 15, 10, 5, 16, 30, 17, 30, 0, 0, 63, 63};

    initial begin
        n_vec = 0;
        n_err = 0;
        prev_prod = 0;
        ena = 1'b1;
        rst_n = 1'b1;
        a = '0;
        b = '0;

        // Reset held with random inputs: everything stays at zero.
        for (int i = 0; i < 5; i++) begin
            a = 6'($urandom_range(0, 63));
            b = 6'($urandom_range(0, 63));
            tick();
            check_state("reset", 0, 0, 0);
        end
        rst_n = 1'b0;

        // Directed table (first entry: 3x10 completes 12 cycles after release).
        foreach (dir_a[i]) run_op(dir_a[i], dir_b[i], 1'b0, 0);

        // Latched operands and a 3-cycle stall mid-operation.
        run_op(-5, 7, 1'b1, 0);
        run_op(6, 9, 1'b0, 4);
        run_op(-7, 12, 1'b1, 1);

        // Reset mid-operation: aborts and clears the published product.
        a = 6'(9);
        b = 6'(20);
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_state("abort", 0, 0, 0);
        rst_n = 1'b0;
        prev_prod = 0;
        run_op(-6, 6, 1'b0, 0);

        // Randomized operations.
        for (int k = 0; k < 40; k++) begin
            int ra;
            int rb;
            ra = $urandom_range(0, 63) - 32;
            rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 20);
            run_op(ra, rb, ($urandom_range(0, 1) == 1), (rb > 1) ? $urandom_range(0, rb - 1) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/repeated_adder_unit.md
Name: repeated_adder_unit

Overview:
- Sequential signed × unsigned multiplier built from repeated addition: product = a added to itself b times, one addition per enabled clock.
- Used in the PID controller datapath to form the integral-term contribution (error × integral constant).
- Exposes a 6-bit signed saturated product, the 16-bit running accumulator, and an addition counter for observability.

Parameters:
- IN_W, 6, width of operands a and b.
- ACC_W, 16, width of the accumulator and of temp_result.
- OUT_W, 6, width of the clipped product a_times_b.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-high reset. Despite the name, 1 = reset, sampled on the rising edge of clk.
- ena  input  1  clock enable; when 0, all state and outputs hold.
- a  input  6  signed two's-complement multiplicand (error).
- b  input  6  unsigned repeat count (integral constant), 0..63.
- a_times_b  output  6  signed product, clipped to OUT_W; registered.
- temp_result  output  16  signed running accumulator; registered.
- flag  output  6  number of additions completed in the current operation; registered.

Behaviour:
- Reset (rst_n=1 at a rising edge):
  - a_times_b=0, temp_result=0, flag=0.
  - Internal operand latches = 0; FSM = LOAD.
  - Reset has priority over ena.
  - Reset asserted mid-operation aborts the operation with no partial result published.
- FSM states and transitions (taken only when ena=1):
  - LOAD: latch a_l=a and b_l=b; temp_result=0; flag=0. Go to ADD if b≠0, else to DONE.
  - ADD: temp_result += sign-extend(a_l) to 16 bits; flag += 1. When the new flag equals b_l, go to DONE; otherwise stay in ADD.
  - DONE: a_times_b = clip(temp_result). temp_result and flag hold. Go to LOAD.
- Latency:
  - Operands are sampled in LOAD.
  - a_times_b updates b+2 enabled cycles later (1 LOAD + b ADD + 1 DONE).
  - The unit then immediately restarts on the current inputs.
- Input changes during ADD/DONE are ignored until the next LOAD.
- a_times_b holds its previous value throughout an operation; it changes only in DONE.
- Clip rule: result > 31 → 31 (011111); result < −32 → −32 (100000); otherwise the low 6 bits.
- Accumulator range: maximum magnitude is 32×63 = 2016, so the 16-bit accumulator never overflows; temp_result[15] is the product sign.
- b=0: LOAD → DONE; a_times_b=0; flag=0.
- a=0: b additions of 0 are performed; result 0; flag=b.
- ena=0: FSM, counters and outputs freeze. The operation resumes on the same cycle count when ena returns to 1.

Optional Feature:
- Macro: REPEATED_ADDER_SAT_EN.
- Defined (the default build): DONE applies the saturating clip rule above.
- Undefined: DONE loads a_times_b with temp_result[5:0], i.e. two's-complement wrap-around (e.g. 2×16 → −32, −2×17 → 30).
- temp_result and flag behave identically either way.

Test Plan:
- Reset: hold rst_n=1 for 5 cycles with random a,b → a_times_b=0, temp_result=0, flag=0 throughout. Release with a=3, b=10 → a_times_b=30 at cycle 12 after release; flag reaches 10.
- Positive range: (a,b)=(1,30),(2,15),(4,5) → a_times_b = 30, 30, 20; temp_result equals the exact product; temp_result[15]=0.
- Negative range: (a,b)=(−1,30),(−2,15),(−3,10),(−4,5) → a_times_b = −30, −30, −30, −20; temp_result[15]=1.
- Clipping, macro defined: (2,16) → temp_result=32, a_times_b=31; (2,30) → 60, 31; (−2,17) → −34, −32; (−2,30) → −60, −32.
- Edges: b=0 → result 0 after 2 cycles, flag=0. Change a mid-ADD → result uses the latched a. Drop ena for 3 cycles mid-ADD → completion is delayed by exactly 3 cycles with the same result.
- Macro undefined: (2,16) → a_times_b=−32; (−2,17) → a_times_b=30.
